// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the sequence-detector slice: FSM state encoding
// and the default pattern width used by both serializer and detector.
package seq_serializer_pkg;

    localparam int DEFAULT_WIDTH = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_serializer.sv
// Loads a variable-length pattern and streams it MSB-first, one bit per
// clock, to the downstream sequence detector; pulses done after the last bit.
module seq_serializer
    import seq_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] load_len,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [CNT_W-1:0] eff_len;
    logic [WIDTH-1:0] aligned;

    // Left-justify the active field so the shifter always emits from the MSB.
    always_comb begin
        eff_len = load_len;
        if (load_len == '0 || load_len > WIDTH_C) begin
            eff_len = WIDTH_C;
        end
        aligned = load_data << (WIDTH_C - eff_len);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            cnt_reg    <= '0;
            x          <= 1'b0;
            x_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_valid) begin
                        // First bit goes straight to x so it appears the cycle after transfer.
                        x          <= aligned[WIDTH-1];
                        shift_reg  <= aligned << 1;
                        cnt_reg    <= eff_len - CNT_W'(1);
                        x_valid    <= 1'b1;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
                        state_reg  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_reg == '0) begin
                        x         <= 1'b0;
                        x_valid   <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        x         <= shift_reg[WIDTH-1];
                        shift_reg <= shift_reg << 1;
                        cnt_reg   <= cnt_reg - CNT_W'(1);
                    end
                end
                DONE: begin
                    done       <= 1'b0;
                    load_ready <= 1'b1;
                    state_reg  <= IDLE;
                end
                default: begin
                    x          <= 1'b0;
                    x_valid    <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    load_ready <= 1'b1;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 Parameter: WIDTH, default 28, maximum pattern length in bits.
REQ-002 Parameter: CNT_W, default clog2(WIDTH+1), bit-counter width; SHALL NOT be overridden by the instantiator.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-low (asserted when 0).
REQ-005 Port: load_valid  input  1  new pattern offered.
REQ-006 Port: load_ready  output  1  block can accept a pattern.
REQ-007 Port: load_data  input  WIDTH  pattern; active field is load_data[len-1:0].
REQ-008 Port: load_len  input  CNT_W  bits to send; 0 or >WIDTH means WIDTH.
REQ-009 Port: x  output  1  serial bit stream to the downstream sequence detector.
REQ-010 Port: x_valid  output  1  x carries a pattern bit this cycle.
REQ-011 Port: busy  output  1  shift in progress.
REQ-012 Port: done  output  1  one-cycle pulse after the last bit.

Function
REQ-013 Three states SHALL be used: IDLE, SHIFT, DONE.
REQ-014 load_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in SHIFT.
REQ-015 Handshake: transfer occurs at a rising edge with load_valid=1 and load_ready=1; load_data/load_len are captured into internal registers on that edge and IDLE->SHIFT.
REQ-016 load_valid while load_ready=0 SHALL be ignored; no queueing.
REQ-017 Effective length L = load_len if 1 <= load_len <= WIDTH, else WIDTH.
REQ-018 Latency: the first bit (captured bit L-1, MSB-first) SHALL appear on x with x_valid=1 in the cycle immediately after the transfer edge.
REQ-019 In SHIFT, one bit per cycle, descending index, down to bit 0; exactly L cycles with x_valid=1.
REQ-020 After the bit-0 cycle, SHIFT->DONE; in DONE, done=1, x=0, x_valid=0, load_ready=0 for exactly one cycle, then DONE->IDLE.
REQ-021 In IDLE and DONE, x SHALL be 0 and x_valid SHALL be 0.
REQ-022 Minimum spacing between consecutive patterns: L + 2 cycles from transfer edge to next possible transfer edge.
REQ-023 Changes on load_data/load_len after the transfer edge SHALL NOT affect the pattern in flight.
REQ-024 All outputs SHALL be registered (no combinational path from inputs to x, x_valid, done).
REQ-025 Bit counter SHALL count L-1 down to 0; it SHALL NOT wrap; underflow is unreachable.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, x=0, x_valid=0, busy=0, done=0, load_ready=1 after release, counter=0, captured data=0.
REQ-027 Reset asserted mid-SHIFT SHALL abort the pattern; no done pulse SHALL follow.
REQ-028 First transfer after rst release SHALL be possible on the first rising edge with rst=1.

Structure
REQ-029 State encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and default WIDTH SHALL live in the shared sequence-detector package/header, also used by the detector.
REQ-030 No sub-module; a single module containing the FSM, down-counter and shift register.

Verification
REQ-031 load_data=28'b0110_1110_1011_1011_1011_1101_0010, load_len=28 -> x = 0,1,1,0,1,1,1,0,... over cycles 1..28 after transfer, done=1 at cycle 29, load_ready=1 at cycle 30.
REQ-032 load_data=...111 (low 3 bits), load_len=3 -> x=1,1,1 with x_valid=1 for 3 cycles, done at cycle 4; downstream detector out asserts once.
REQ-033 load_len=0 and load_len=31 -> both treated as 28 bits; x_valid high exactly 28 cycles.
REQ-034 rst=0 at cycle 10 of a 28-bit shift -> x, x_valid, busy drop to 0 asynchronously; no done pulse; new pattern accepted right after release.
REQ-035 load_valid held high continuously with changing load_data during SHIFT -> in-flight bits unchanged; next pattern captured only in IDLE, L+2 cycles after previous transfer.
